// File: rtl/mil_tx_channel_if.sv
// Word-push interface between the SPI-side word pusher and the
// MIL-STD-1553 transmit channel. The pusher is the master, the channel is the slave.
interface mil_tx_channel_if #(
    parameter int DATA_W = 16
);
    logic              push_valid;
    logic              push_ready;
    logic [DATA_W-1:0] push_data;
    logic [1:0]        push_type;
    logic              push_bus;

    modport master (
        output push_valid,
        output push_data,
        output push_type,
        output push_bus,
        input  push_ready
    );

    modport slave (
        input  push_valid,
        input  push_data,
        input  push_type,
        input  push_bus,
        output push_ready
    );
endinterface

// File: rtl/mil_tx_channel.sv
// MIL-STD-1553 Manchester-II word transmitter for dual-redundant buses (A/B).
// Words are queued in a small FIFO and sent as SYNC / DATA / PARITY.
// Words for the same bus are sent back-to-back while grant is held.
// A word for the other bus, or an empty queue, closes the burst with an idle GAP.
// Optional feature macro MIL_TX_DUAL_BUS_EN: when defined, push_bus selects bus A/B.
// When undefined, every word goes out on bus A and txB/ntxB are tied low.
module mil_tx_channel #(
    parameter int CLK_PER_HALFBIT = 25,
    parameter int DATA_W          = 16,
    parameter int FIFO_DEPTH      = 4,
    parameter int GAP_HALFBITS    = 4
) (
    input  logic                        clk,
    input  logic                        nRst,
    mil_tx_channel_if.slave             pif,
    input  logic                        grant,
    output logic                        request,
    output logic                        busy,
    output logic                        txA,
    output logic                        ntxA,
    output logic                        txB,
    output logic                        ntxB,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        drop_pulse
);
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int CW     = $clog2(CLK_PER_HALFBIT);
    localparam int HB_M1  = (2 * DATA_W > GAP_HALFBITS) ? 2 * DATA_W : GAP_HALFBITS;
    localparam int HB_MAX = (HB_M1 > 6) ? HB_M1 : 6;
    localparam int HB_W   = $clog2(HB_MAX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_DATA,
        S_PARITY,
        S_GAP
    } state_t;

    // FIFO storage and pointers; entry layout is {bus, service, data}
    logic [DATA_W+1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       count_q, count_d;
    logic              full, empty;
    logic              push_acc, push_err, push_wr;
    logic              wr_bus;
    logic              drop_q;

    logic [DATA_W+1:0] head;
    logic              head_bus, head_svc;
    logic [DATA_W-1:0] head_data;

    // Transmit sequencer state
    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [HB_W-1:0]   hb_q, hb_d;
    logic              act_bus_q, act_bus_d;
    logic              tick, last_hb, load, shift;

    // Word being serialised
    logic [DATA_W-1:0] sh_q;
    logic              par_q;
    logic              svc_q;

    logic              line, drive;

`ifdef MIL_TX_DUAL_BUS_EN
    assign wr_bus = pif.push_bus;
`else
    logic unused_push_bus;
    assign unused_push_bus = pif.push_bus;
    assign wr_bus          = 1'b0;
`endif

    assign full      = (count_q == (AW+1)'(FIFO_DEPTH));
    assign empty     = (count_q == '0);
    assign push_acc  = pif.push_valid && !full;
    assign push_err  = pif.push_type[1];
    assign push_wr   = push_acc && !push_err;

    assign head      = mem_q[rd_ptr_q];
    assign head_bus  = head[DATA_W+1];
    assign head_svc  = head[DATA_W];
    assign head_data = head[DATA_W-1:0];

    assign tick      = (cnt_q == CW'(CLK_PER_HALFBIT - 1));
    assign shift     = (state_q == S_DATA) && tick && hb_q[0];

    // Occupancy: a push and a pop in the same cycle cancel out
    always_comb begin
        count_d = count_q;
        case ({push_wr, load})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Last half-bit of the current segment
    always_comb begin
        last_hb = 1'b0;
        case (state_q)
            S_SYNC:   last_hb = (hb_q == HB_W'(5));
            S_DATA:   last_hb = (hb_q == HB_W'(2 * DATA_W - 1));
            S_PARITY: last_hb = (hb_q == HB_W'(1));
            S_GAP:    last_hb = (hb_q == HB_W'(GAP_HALFBITS - 1));
            default:  last_hb = 1'b0;
        endcase
    end

    // Next-state logic: segment sequencing, word loads and the half-bit timer
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hb_d      = hb_q;
        act_bus_d = act_bus_q;
        load      = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                hb_d  = '0;
                if (!empty && grant) begin
                    load      = 1'b1;
                    act_bus_d = head_bus;
                    state_d   = S_SYNC;
                end
            end
            default: begin
                cnt_d = tick ? '0 : cnt_q + CW'(1);
                if (tick) begin
                    hb_d = last_hb ? '0 : hb_q + HB_W'(1);
                    if (last_hb) begin
                        case (state_q)
                            S_SYNC: state_d = S_DATA;
                            S_DATA: state_d = S_PARITY;
                            S_PARITY: begin
                                // Same-bus follow-on word starts with no gap
                                if (!empty && grant && (head_bus == act_bus_q)) begin
                                    load    = 1'b1;
                                    state_d = S_SYNC;
                                end else begin
                                    state_d = S_GAP;
                                end
                            end
                            default: state_d = S_IDLE;
                        endcase
                    end
                end
            end
        endcase
        if (load) begin
            cnt_d = '0;
        end
    end

    // Control registers: FIFO pointers, sequencer state, timer and drop flag
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            drop_q    <= 1'b0;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            hb_q      <= '0;
            act_bus_q <= 1'b0;
        end else begin
            if (push_wr) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (load) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q   <= count_d;
            drop_q    <= push_acc && push_err;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hb_q      <= hb_d;
            act_bus_q <= act_bus_d;
        end
    end

    // FIFO storage write; contents are only meaningful where count says so
    always_ff @(posedge clk) begin
        if (push_wr) begin
            mem_q[wr_ptr_q] <= {wr_bus, pif.push_type[0], pif.push_data};
        end
    end

    // Word shift register: load on pop, advance one bit after each bit's second half
    always_ff @(posedge clk) begin
        if (load) begin
            sh_q  <= head_data;
            par_q <= ~^head_data;
            svc_q <= head_svc;
        end else if (shift) begin
            sh_q <= sh_q << 1;
        end
    end

    // Line level per segment; each bit is sent as value then inverse
    always_comb begin
        line  = 1'b0;
        drive = 1'b0;
        case (state_q)
            S_SYNC: begin
                drive = 1'b1;
                line  = (hb_q < HB_W'(3)) ? svc_q : ~svc_q;
            end
            S_DATA: begin
                drive = 1'b1;
                line  = hb_q[0] ? ~sh_q[DATA_W-1] : sh_q[DATA_W-1];
            end
            S_PARITY: begin
                drive = 1'b1;
                line  = hb_q[0] ? ~par_q : par_q;
            end
            default: begin
                drive = 1'b0;
                line  = 1'b0;
            end
        endcase
    end

    assign txA  = drive & ~act_bus_q & line;
    assign ntxA = drive & ~act_bus_q & ~line;
`ifdef MIL_TX_DUAL_BUS_EN
    assign txB  = drive & act_bus_q & line;
    assign ntxB = drive & act_bus_q & ~line;
`else
    assign txB  = 1'b0;
    assign ntxB = 1'b0;
`endif

    assign pif.push_ready = !full;
    assign busy           = (state_q != S_IDLE);
    assign request        = !empty || busy;
    assign fifo_level     = count_q;
    assign drop_pulse     = drop_q;
endmodule

// File: tb/tb_mil_tx_channel.sv
// Scoreboard bench for mil_tx_channel: pushed words are queued as expectations,
// an independent monitor decodes every word seen on the bus lines and compares
// it with a Manchester waveform computed from the word value.
`timescale 1ns/1ps
module tb_mil_tx_channel;
    localparam int CPH      = 25;
    localparam int DW       = 16;
    localparam int DEPTH    = 4;
    localparam int GAPH     = 4;
    localparam int WORD_HB  = 8 + 2 * DW;
    localparam int WORD_CLK = WORD_HB * CPH;
    localparam int GAP_CLK  = GAPH * CPH;
`ifdef MIL_TX_DUAL_BUS_EN
    localparam bit DUAL = 1'b1;
`else
    localparam bit DUAL = 1'b0;
`endif

    logic clk = 1'b0;
    logic nRst = 1'b0;
    logic grant = 1'b0;
    logic request, busy, txA, ntxA, txB, ntxB, drop_pulse;
    logic [$clog2(DEPTH):0] fifo_level;

    mil_tx_channel_if #(.DATA_W(DW)) pif ();

    mil_tx_channel #(
        .CLK_PER_HALFBIT(CPH),
        .DATA_W(DW),
        .FIFO_DEPTH(DEPTH),
        .GAP_HALFBITS(GAPH)
    ) dut (
        .clk(clk),
        .nRst(nRst),
        .pif(pif),
        .grant(grant),
        .request(request),
        .busy(busy),
        .txA(txA),
        .ntxA(ntxA),
        .txB(txB),
        .ntxB(ntxB),
        .fifo_level(fifo_level),
        .drop_pulse(drop_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          bus;
        logic          svc;
        logic [DW-1:0] data;
    } exp_t;

    exp_t exp_q[$];

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    endtask

    // Reference waveform: 40 half-bit line levels for one word
    function automatic logic [WORD_HB-1:0] model_wave(input logic svc, input logic [DW-1:0] d);
        logic [WORD_HB-1:0] w;
        logic p;
        int k;
        w = '0;
        k = WORD_HB - 1;
        for (int i = 0; i < 6; i++) begin
            w[k] = svc ? (i < 3) : (i >= 3);
            k--;
        end
        for (int i = DW - 1; i >= 0; i--) begin
            w[k] = d[i];
            k--;
            w[k] = ~d[i];
            k--;
        end
        p = 1'b1;
        for (int i = 0; i < DW; i++) p = p ^ d[i];
        w[k] = p;
        k--;
        w[k] = ~p;
        return w;
    endfunction

    // Monitor state
    bit                 in_word = 0;
    int                 wcyc = 0;
    logic [WORD_HB-1:0] cap;
    logic               cap_bus;
    int                 werr = 0;
    logic               hb_level;
    int                 busy_len = 0;
    int                 run_words = 0;
    bit                 prev_busy = 0;
    int                 rule_err = 0;
    logic               mon_aA, mon_aB, mon_line;
    exp_t               mon_e;

    // Monitor: decode bus activity on the falling edge, compare against the queue
    always @(negedge clk) begin
        if (!nRst) begin
            in_word   = 0;
            busy_len  = 0;
            run_words = 0;
            prev_busy = 0;
        end else begin
            if (request !== ((fifo_level != 0) || busy)) rule_err++;
            if (pif.push_ready !== (fifo_level != DEPTH)) rule_err++;
            if (busy) busy_len++;
            mon_aA = txA | ntxA;
            mon_aB = txB | ntxB;
            if (!in_word && (mon_aA || mon_aB)) begin
                in_word = 1;
                wcyc    = 0;
                cap_bus = mon_aB;
                werr    = 0;
                cap     = '0;
                check("word_start_offset", busy_len, run_words * WORD_CLK + 1);
            end
            if (in_word) begin
                mon_line = cap_bus ? txB : txA;
                if (cap_bus ? ((ntxB !== ~txB) || mon_aA) : ((ntxA !== ~txA) || mon_aB)) werr++;
                if (!busy) werr++;
                if (wcyc % CPH == 0) hb_level = mon_line;
                else if (mon_line !== hb_level) werr++;
                if (wcyc % CPH == CPH / 2) cap[WORD_HB - 1 - wcyc / CPH] = mon_line;
                wcyc++;
                if (wcyc == WORD_CLK) begin
                    in_word = 0;
                    run_words++;
                    check("word_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        mon_e = exp_q.pop_front();
                        check("word_bus", cap_bus, mon_e.bus);
                        check("word_wave", cap, model_wave(mon_e.svc, mon_e.data));
                        check("word_integrity", werr, 0);
                    end
                end
            end
            if (prev_busy && !busy) begin
                check("busy_len", busy_len, run_words * WORD_CLK + GAP_CLK);
                busy_len  = 0;
                run_words = 0;
            end
            prev_busy = busy;
        end
    end

    // Offer one word; caller is positioned just after a rising edge
    task automatic push(input logic [DW-1:0] d, input logic [1:0] t, input logic b);
        int n;
        exp_t e;
        n = 0;
        while (pif.push_ready !== 1'b1 && n < 20000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 20000) begin
            check("push_ready_timeout", n, 0);
            return;
        end
        pif.push_valid = 1'b1;
        pif.push_data  = d;
        pif.push_type  = t;
        pif.push_bus   = b;
        if (!t[1]) begin
            e.bus  = b & DUAL;
            e.svc  = t[0];
            e.data = d;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        pif.push_valid = 1'b0;
        check("drop_pulse", drop_pulse, t[1]);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || fifo_level != 0 || in_word) && n < 30000) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #1;
        check("idle_reached", n < 30000, 1);
        check("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        pif.push_valid = 1'b0;
        pif.push_data  = '0;
        pif.push_type  = 2'd0;
        pif.push_bus   = 1'b0;
        grant          = 1'b0;
        nRst           = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {txA, ntxA, txB, ntxB, busy, request, drop_pulse}, 0);
        check("reset_level", fifo_level, 0);
        check("reset_ready", pif.push_ready, 1);
        nRst = 1'b1;
        @(posedge clk);
        #1;

        // Single DATA word on bus A
        grant = 1'b1;
        push(16'hA5A5, 2'd0, 1'b0);
        wait_idle();

        // SERVICE word on bus B
        push(16'h0000, 2'd1, 1'b1);
        wait_idle();

        // Two same-bus words back-to-back
        push(16'h1234, 2'd0, 1'b0);
        push(16'hFEDC, 2'd0, 1'b0);
        wait_idle();

        // Bus change A then B
        push(16'h0F0F, 2'd0, 1'b0);
        push(16'h8001, 2'd1, 1'b1);
        wait_idle();

        // Error-type word is dropped
        grant = 1'b0;
        push(16'h5555, 2'd2, 1'b0);
        check("drop_level", fifo_level, 0);
        check("drop_request", request, 0);
        check("drop_ready", pif.push_ready, 1);
        @(posedge clk);
        #1;
        check("drop_pulse_one_cycle", drop_pulse, 0);

        // Fill the FIFO without grant
        for (int i = 0; i < DEPTH; i++) push(DW'($urandom), 2'd0, 1'b0);
        check("full_ready", pif.push_ready, 0);
        check("full_level", fifo_level, DEPTH);
        check("full_request", request, 1);
        pif.push_valid = 1'b1;
        pif.push_data  = 16'hDEAD;
        pif.push_type  = 2'd0;
        @(posedge clk);
        #1;
        pif.push_valid = 1'b0;
        check("full_level_hold", fifo_level, DEPTH);

        // Reset in the middle of SYNC
        grant = 1'b1;
        repeat (40) @(posedge clk);
        #3;
        check("mid_sync_busy", busy, 1);
        nRst = 1'b0;
        #1;
        check("async_reset_outputs", {txA, ntxA, txB, ntxB, busy, request, drop_pulse}, 0);
        check("async_reset_level", fifo_level, 0);
        check("async_reset_ready", pif.push_ready, 1);
        exp_q.delete();
        @(posedge clk);
        #1;
        nRst = 1'b1;
        @(posedge clk);
        #1;

        // Randomised traffic with grant gaps
        for (int w = 0; w < 24; w++) begin
            int gap;
            grant = ($urandom_range(0, 3) != 0);
            if (fifo_level == DEPTH) grant = 1'b1;
            push(DW'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            gap = $urandom_range(0, 1200);
            for (int c = 0; c < gap; c++) begin
                @(posedge clk);
                #1;
            end
        end
        grant = 1'b1;
        wait_idle();
        check("request_ready_rules", rule_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
